// File: rtl/board_cell_writer_pkg.sv
// Shared TicTacToe board encodings: marks, write error codes, writer FSM states.
package board_cell_writer_pkg;

  localparam int CELLS_DEF = 9;
  localparam int IDX_W     = 4;

  localparam logic [1:0] MARK_EMPTY = 2'b00;
  localparam logic [1:0] MARK_X     = 2'b01;
  localparam logic [1:0] MARK_O     = 2'b10;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_OCC  = 2'b01;
  localparam logic [1:0] ERR_IDX  = 2'b10;
  localparam logic [1:0] ERR_MARK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } wr_state_e;

endpackage

// File: rtl/board_cell_writer_cell_wr_decoder.sv
// Index + enable to one-hot cell write strobe; out-of-range indices give all zeros.
// Purely combinational, no backpressure.
module cell_wr_decoder
  import board_cell_writer_pkg::*;
#(
  parameter int CELLS = CELLS_DEF
) (
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [CELLS-1:0] strb_o
);

  always_comb begin
    strb_o = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (en_i && (idx_i == IDX_W'(i))) strb_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/board_cell_writer.sv
// Board store write side: validated cell writes (result 2 cycles after handshake) and a
// one-cell-per-cycle clear sweep; wr_ready drops while busy or while clr is requested.
module board_cell_writer
  import board_cell_writer_pkg::*;
#(
  parameter int N     = 2,
  parameter int CELLS = CELLS_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [N-1:0]       wr_mark,
  output logic               wr_done,
  output logic [1:0]         wr_err,
  input  logic               clr,
  output logic               clr_done,
  output logic [N*CELLS-1:0] board,
  output logic [3:0]         move_cnt,
  output logic               full
);

  wr_state_e          state_q, state_d;
  logic [N*CELLS-1:0] board_q, board_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       mark_q, mark_d;
  logic               done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic               clr_done_q, clr_done_d;

  logic [N-1:0]       tgt;
  logic               idx_bad, mark_bad, occupied, wr_ok;
  logic               dec_en;
  logic [IDX_W-1:0]   dec_idx;
  logic [CELLS-1:0]   strb;
  logic [N-1:0]       cell_dat;

  // Current content of the latched target cell; stays empty for out-of-range indices.
  always_comb begin
    tgt = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (idx_q == IDX_W'(i)) tgt = board_q[N*i +: N];
    end
  end

  assign idx_bad  = (idx_q >= IDX_W'(CELLS));
  assign mark_bad = (mark_q == '0) || (mark_q == '1);
  assign occupied = (tgt != '0);
  assign wr_ok    = !idx_bad && !mark_bad && !occupied;

  assign dec_en   = ((state_q == ST_WRITE) && wr_ok) || (state_q == ST_CLEAR);
  assign dec_idx  = (state_q == ST_CLEAR) ? ptr_q : idx_q;
  assign cell_dat = (state_q == ST_CLEAR) ? '0 : mark_q;

  cell_wr_decoder #(.CELLS(CELLS)) u_dec (
    .en_i   (dec_en),
    .idx_i  (dec_idx),
    .strb_o (strb)
  );

  always_comb begin
    board_d = board_q;
    for (int i = 0; i < CELLS; i++) begin
      if (strb[i]) board_d[N*i +: N] = cell_dat;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    mark_d     = mark_q;
    done_d     = 1'b0;
    err_d      = err_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (wr_valid) begin
          idx_d   = wr_idx;
          mark_d  = wr_mark;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (idx_bad)       err_d = ERR_IDX;
        else if (mark_bad) err_d = ERR_MARK;
        else if (occupied) err_d = ERR_OCC;
        else begin
          err_d = ERR_OK;
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == IDX_W'(CELLS - 1)) begin
          ptr_d      = '0;
          cnt_d      = '0;
          clr_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      board_q    <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      mark_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= ERR_OK;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      mark_q     <= mark_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign wr_ready = (state_q == ST_IDLE) && !clr;
  assign wr_done  = done_q;
  assign wr_err   = err_q;
  assign clr_done = clr_done_q;
  assign board    = board_q;
  assign move_cnt = cnt_q;
  assign full     = (cnt_q == 4'(CELLS));

endmodule

// File: tb/tb_board_cell_writer.sv
// Bench for board_cell_writer: directed vector table, clear/reset corner sequences, then
// randomized writes and clears compared against a cell-array model of the game board.
module tb_board_cell_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_idx;
  logic [1:0]  wr_mark;
  logic        wr_done;
  logic [1:0]  wr_err;
  logic        clr;
  logic        clr_done;
  logic [17:0] board;
  logic [3:0]  move_cnt;
  logic        full;

  int checks = 0;
  int errors = 0;

  logic [1:0] m [9];
  int         mcnt;

  board_cell_writer #(.N(2), .CELLS(9)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_idx   (wr_idx),
    .wr_mark  (wr_mark),
    .wr_done  (wr_done),
    .wr_err   (wr_err),
    .clr      (clr),
    .clr_done (clr_done),
    .board    (board),
    .move_cnt (move_cnt),
    .full     (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic [1:0] mark;
    logic [1:0] err;
    logic [3:0] cnt;
    logic       full;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] flat();
    logic [17:0] f;
    f = '0;
    for (int i = 0; i < 9; i++) f[2*i +: 2] = m[i];
    return f;
  endfunction

  function automatic logic [1:0] model_write(input logic [3:0] idx, input logic [1:0] mark);
    if (idx >= 9) return 2'b10;
    if (mark == 2'b00 || mark == 2'b11) return 2'b11;
    if (m[idx] != 2'b00) return 2'b01;
    m[idx] = mark;
    mcnt++;
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m[i] = 2'b00;
    mcnt = 0;
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [1:0] mark, output logic [1:0] err_o);
    int n;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_idx   = idx;
    wr_mark  = mark;
    n = 0;
    while (!wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL wr_ready_timeout: ready never rose within 50 cycles");
    end
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    check("wr_done_k1", wr_done, 1'b0);
    @(negedge clk);
    check("wr_done_k2", wr_done, 1'b1);
    err_o = wr_err;
  endtask

  task automatic do_clear();
    int n;
    @(negedge clk);
    clr = 1'b1;
    #1 check("clr_ready_low", wr_ready, 1'b0);
    @(posedge clk);
    #1 clr = 1'b0;
    n = 0;
    while (!clr_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("clr_cycles", n, 10);
    check("clr_board", board, 18'h0);
    check("clr_cnt", move_cnt, 4'd0);
    model_clear();
  endtask

  initial begin
    logic [1:0]  e;
    logic [1:0]  exp_e;
    logic [17:0] pre;
    logic [3:0]  ridx;
    logic [1:0]  rmark;
    int          n;
    int          pulses;
    bit          seen;

    reset_n = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_mark = '0; clr = 1'b0;
    model_clear();

    vecs[0]  = '{4'd4,  2'd1, 2'b00, 4'd1, 1'b0};
    vecs[1]  = '{4'd4,  2'd2, 2'b01, 4'd1, 1'b0};
    vecs[2]  = '{4'd12, 2'd1, 2'b10, 4'd1, 1'b0};
    vecs[3]  = '{4'd0,  2'd3, 2'b11, 4'd1, 1'b0};
    vecs[4]  = '{4'd15, 2'd0, 2'b10, 4'd1, 1'b0};
    vecs[5]  = '{4'd0,  2'd2, 2'b00, 4'd2, 1'b0};
    vecs[6]  = '{4'd1,  2'd1, 2'b00, 4'd3, 1'b0};
    vecs[7]  = '{4'd2,  2'd2, 2'b00, 4'd4, 1'b0};
    vecs[8]  = '{4'd3,  2'd1, 2'b00, 4'd5, 1'b0};
    vecs[9]  = '{4'd5,  2'd2, 2'b00, 4'd6, 1'b0};
    vecs[10] = '{4'd6,  2'd1, 2'b00, 4'd7, 1'b0};
    vecs[11] = '{4'd7,  2'd2, 2'b00, 4'd8, 1'b0};
    vecs[12] = '{4'd8,  2'd1, 2'b00, 4'd9, 1'b1};
    vecs[13] = '{4'd2,  2'd1, 2'b01, 4'd9, 1'b1};
    vecs[14] = '{4'd6,  2'd2, 2'b01, 4'd9, 1'b1};

    #12;
    check("rst_board", board, 18'h0);
    check("rst_cnt", move_cnt, 4'd0);
    check("rst_done", wr_done, 1'b0);
    check("rst_err", wr_err, 2'b00);
    check("rst_clr_done", clr_done, 1'b0);
    check("rst_ready", wr_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 15; v++) begin
      do_write(vecs[v].idx, vecs[v].mark, e);
      if (vecs[v].err == 2'b00) m[vecs[v].idx] = vecs[v].mark;
      check($sformatf("vec%0d_err", v), e, vecs[v].err);
      check($sformatf("vec%0d_cnt", v), move_cnt, vecs[v].cnt);
      check($sformatf("vec%0d_full", v), full, vecs[v].full);
      check($sformatf("vec%0d_board", v), board, flat());
    end
    mcnt = 9;

    // clr and wr_valid together: clear wins, write is held and taken afterwards
    pre = flat();
    @(negedge clk);
    clr = 1'b1; wr_valid = 1'b1; wr_idx = 4'd4; wr_mark = 2'd2;
    #1 check("clrwr_ready_low", wr_ready, 1'b0);
    @(posedge clk);
    #1 clr = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        check("clr_partial_lo", board[7:0], 8'h0);
        check("clr_partial_hi", board[17:8], pre[17:8]);
      end
      if (clr_done) seen = 1;
      else check("clr_busy_ready", wr_ready, 1'b0);
    end
    check("clrwr_cycles", n, 10);
    check("clrwr_board", board, 18'h0);
    check("clrwr_cnt", move_cnt, 4'd0);
    check("clrwr_full", full, 1'b0);
    check("clrwr_ready_back", wr_ready, 1'b1);
    model_clear();
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_e = model_write(4'd4, 2'd2);
    check("held_done", wr_done, 1'b1);
    check("held_err", wr_err, exp_e);
    check("held_board", board, flat());
    check("held_cnt", move_cnt, 4'd1);

    // reset in the middle of a clear sweep
    do_write(4'd4, 2'd1, e);
    check("occ_err", e, 2'b01);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (6) @(negedge clk);
    check("midclr_cnt_before", move_cnt, 4'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_board", board, 18'h0);
    check("midrst_cnt", move_cnt, 4'd0);
    check("midrst_full", full, 1'b0);
    check("midrst_done", wr_done, 1'b0);
    check("midrst_err", wr_err, 2'b00);
    check("midrst_clr_done", clr_done, 1'b0);
    check("midrst_ready", wr_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (clr_done) pulses++;
    end
    check("midrst_no_clr_done", pulses, 0);
    model_clear();

    // randomized writes and clears against the board model
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_clear();
      end else begin
        ridx  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        rmark = 2'($urandom_range(0, 3));
        do_write(ridx, rmark, e);
        exp_e = model_write(ridx, rmark);
        check("rnd_err", e, exp_e);
        check("rnd_board", board, flat());
        check("rnd_cnt", move_cnt, 4'(mcnt));
        check("rnd_full", full, mcnt == 9);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
